seg_display: RTL and testbench
==============================

# seg_display

Memory-mapped output device driving an 8-digit, time-multiplexed, common-anode seven-segment display. It is the CPU-write counterpart of the DIP-switch input device and sits on the same peripheral bus. Software stores a 32-bit value, shown as 8 hex digits, plus a control word. The block scans one digit at a time, decodes its nibble to active-low segments, and returns either register on read.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected; legal range ≥ 2.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `addr`  in  1: register select; 0 = DATA, 1 = CTRL.
- `we`  in  1: write strobe, sampled on the rising edge of `clk`.
- `be`  in  4: byte enables for writes; `be[i]` gates `Din[8i+7:8i]`.
- `Din`  in  32: write data.
- `Dout`  out  32: registered read data for the register selected by `addr`.
- `seg_n`  out  8: segments, active-low; bit 0 = a … bit 6 = g, bit 7 = dp.
- `an_n`  out  8: digit selects, active-low, one-hot-low; bit k = digit k, where digit 0 is the rightmost and shows `DATA[3:0]`.

## Operation
- DATA register, 32 bits: digit k shows `DATA[4k+3:4k]`.
- CTRL register:
  - bit 0 = EN.
  - bits [15:8] = DP mask; 1 lights dp on digit k−8.
  - bits [23:16] = BLANK mask; 1 blanks digit k−16.
  - Other bits are not stored and read as 0.
- Write: when `we`=1, each byte with `be[i]`=1 is updated in the addressed register. Bytes with `be[i]`=0 are unchanged. `be`=0000 with `we`=1 is a no-op.
- Read: `Dout` ← addressed register every cycle, independent of `we`.
- Scan engine:
  - Free-running divider `div` counts 0 … SCAN_DIV−1.
  - When `div` = SCAN_DIV−1: `div` returns to 0 and digit index `idx` (3 bits) increments, wrapping 7 → 0.
  - The engine runs regardless of EN.
- Output register, updated every cycle from the current state:
  - EN=0: `an_n` = 8'hFF, `seg_n` = 8'hFF.
  - EN=1: `an_n` = ~(1 << idx).
    - `seg_n[6:0]` = decoded nibble, or 7'h7F if BLANK[idx] is set.
    - `seg_n[7]` = ~DP[idx], or 1 if BLANK[idx] is set.
- Hex decode, active-low {g..a}:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E

## Timing
- Reset, asynchronous, takes effect immediately:
  - DATA = 0, CTRL = 0, `div` = 0, `idx` = 0.
  - `Dout` = 0, `seg_n` = 8'hFF, `an_n` = 8'hFF.
- After reset release, the first scan step occurs at edge SCAN_DIV.
- Write latency:
  - The register updates at the edge where `we` is sampled.
  - The display reflects the new value on `seg_n`/`an_n` after the next edge, i.e. 1 cycle of output-register latency.
- Read latency: 1 cycle. `Dout` at edge n+1 reflects `addr` and register contents at edge n, so a write at edge n is visible on `Dout` after edge n+1.
- Simultaneous write and scan step:
  - Both take effect.
  - The next output uses the old register value with the new `idx`.
  - The new value appears one cycle later.
- Enabling or disabling EN mid-scan does not reset `div` or `idx`. Outputs switch on the cycle after the write is captured.
- Reset asserted mid-scan: the display blanks immediately; no partial digit is held.
- `an_n` never has more than one bit low in any cycle.

## Structure
- Shared peripheral package holds:
  - Register offsets: `SEG_DATA` = 0, `SEG_CTRL` = 1.
  - CTRL field positions: EN, DP_LSB, BLANK_LSB.
  - The all-off constant 8'hFF.
- One sub-module, `hex7seg_decoder`: combinational 4-bit → 7-bit active-low decode.
- Expected size: roughly 150 lines of RTL excluding the decoder.

## Test plan
- Reset: hold `reset`=1 mid-run → `seg_n` = FF, `an_n` = FF, `Dout` = 0 immediately; after release with EN=0, outputs stay FF.
- Write DATA = 32'h89ABCDEF, then CTRL = 1, with SCAN_DIV = 4 → every 4 cycles `an_n` steps FE, FD, FB, … 7F, FE. Required `seg_n` per digit:
  - digit 0: 8E
  - digit 1: 86
  - digit 2: A1
  - digit 3: C6
  - digit 4: 83
  - digit 5: 88
  - digit 6: 90
  - digit 7: 80
- Byte enables: DATA = 32'h12345678, then write Din = 32'hFFFFFFFF with `be` = 0100 → read DATA gives 32'h12FF5678 one cycle after the read address is presented.
- DP/BLANK: CTRL = 32'h00_02_01_01 → digit 0 dp lit (`seg_n[7]` = 0); digit 1 `seg_n` = FF with `an_n` = FD; other digits dp off.
- CTRL readback: write 32'hFFFFFFFF → read returns 32'h00FFFF01.
- Write during scan step: a DATA write at the same edge `idx` advances → old nibble shown for one cycle, new nibble from the next cycle.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared peripheral definitions for the seven-segment display device:
// register offsets, CTRL field positions and the all-segments-off pattern.
package seg_display_pkg;

  typedef enum logic {
    SEG_DATA = 1'b0,
    SEG_CTRL = 1'b1
  } seg_reg_e;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_DP_LSB    = 8;
  localparam int CTRL_BLANK_LSB = 16;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  // Rebuild the 32-bit CTRL word from its stored fields; unstored bits read 0.
  function automatic logic [31:0] ctrl_pack(input logic       en,
                                            input logic [7:0] dp,
                                            input logic [7:0] blank);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]                 = en;
    w[CTRL_DP_LSB +: 8]        = dp;
    w[CTRL_BLANK_LSB +: 8]     = blank;
    return w;
  endfunction

endpackage

// File: rtl/seg_display_if.sv
// Peripheral bus port of the display device: register select, write strobe,
// byte enables, write data and registered read data.
interface seg_display_if;
  logic        addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output addr, output we, output be, output Din, input Dout);
  modport slave  (input addr, input we, input be, input Din, output Dout);
endinterface

// File: rtl/seg_display_hex7seg.sv
// Combinational hex nibble to active-low {g..a} segment decoder.
module hex7seg_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  // Active-low pattern for each hex digit, bit 0 = segment a.
  always_comb begin
    seg_n_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_n_o = 7'h40;
      4'h1: seg_n_o = 7'h79;
      4'h2: seg_n_o = 7'h24;
      4'h3: seg_n_o = 7'h30;
      4'h4: seg_n_o = 7'h19;
      4'h5: seg_n_o = 7'h12;
      4'h6: seg_n_o = 7'h02;
      4'h7: seg_n_o = 7'h78;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h10;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h03;
      4'hC: seg_n_o = 7'h46;
      4'hD: seg_n_o = 7'h21;
      4'hE: seg_n_o = 7'h06;
      4'hF: seg_n_o = 7'h0E;
      default: seg_n_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display.sv
// Memory-mapped 8-digit multiplexed seven-segment display driver.
// Holds a 32-bit DATA word and a CTRL word (EN, DP mask, BLANK mask),
// scans one digit per SCAN_DIV cycles and drives registered active-low
// segment and anode outputs.
module seg_display
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         reset,
  seg_display_if.slave bus,
  output logic [7:0]   seg_n,
  output logic [7:0]   an_n
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [31:0]      data_q, data_d;
  logic             en_q, en_d;
  logic [7:0]       dp_q, dp_d;
  logic [7:0]       blank_q, blank_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      dout_q, dout_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;

  logic [3:0]       nibble;
  logic [6:0]       hex_seg_n;

  // Byte-enabled register writes into DATA or the stored CTRL fields.
  always_comb begin
    data_d  = data_q;
    en_d    = en_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (bus.we) begin
      if (bus.addr == SEG_DATA) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.be[i]) data_d[8*i +: 8] = bus.Din[8*i +: 8];
        end
      end else begin
        if (bus.be[0]) en_d    = bus.Din[CTRL_EN];
        if (bus.be[1]) dp_d    = bus.Din[CTRL_DP_LSB +: 8];
        if (bus.be[2]) blank_d = bus.Din[CTRL_BLANK_LSB +: 8];
      end
    end
  end

  // Free-running scan divider; the digit index advances on divider wrap.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // The digit about to be selected uses the pre-write register contents,
  // so a write coinciding with a scan step shows up one cycle later.
  assign nibble = data_q[{idx_d, 2'b00} +: 4];

  hex7seg_decoder u_dec (
    .nibble_i (nibble),
    .seg_n_o  (hex_seg_n)
  );

  // Next output word and read data, all from current state.
  always_comb begin
    seg_d  = SEG_ALL_OFF;
    an_d   = SEG_ALL_OFF;
    dout_d = (bus.addr == SEG_CTRL) ? ctrl_pack(en_q, dp_q, blank_q) : data_q;
    if (en_q) begin
      an_d = ~(8'h01 << idx_d);
      if (!blank_q[idx_d]) seg_d = {~dp_q[idx_d], hex_seg_n};
    end
  end

  // All state registers; reset blanks the display at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      dp_q    <= '0;
      blank_q <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      seg_q   <= SEG_ALL_OFF;
      an_q    <= SEG_ALL_OFF;
    end else begin
      data_q  <= data_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.Dout = dout_q;
  assign seg_n    = seg_q;
  assign an_n     = an_q;

endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display with a short scan period.
module tb_seg_display;

  localparam int SD = 4;

  logic       clk;
  logic       reset;
  logic [7:0] seg_n;
  logic [7:0] an_n;

  seg_display_if bus_if ();

  seg_display #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .seg_n (seg_n),
    .an_n  (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;  // rising edges since the last reset release

  logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] SCAN_EXP [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic clk1();
    @(negedge clk);
    k++;
  endtask

  task automatic wr(input logic a, input logic [3:0] b, input logic [31:0] d);
    bus_if.addr = a;
    bus_if.be   = b;
    bus_if.Din  = d;
    bus_if.we   = 1'b1;
    clk1();
    bus_if.we   = 1'b0;
  endtask

  function automatic logic [7:0] an_exp(input int idx);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << idx);
  endfunction

  function automatic logic [7:0] seg_exp(input logic [31:0] d, input int idx,
                                         input logic [7:0] dp, input logic [7:0] bl);
    if (bl[idx]) return 8'hFF;
    return {~dp[idx], DEC[d[4*idx +: 4]]};
  endfunction

  initial begin
    int j;
    reset       = 1'b1;
    bus_if.addr = 1'b0;
    bus_if.we   = 1'b0;
    bus_if.be   = 4'h0;
    bus_if.Din  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'h0, seg_n}, 32'hFF);
    chk("rst_an", {24'h0, an_n}, 32'hFF);
    chk("rst_dout", bus_if.Dout, 32'h0);

    // Release, load DATA and enable
    reset = 1'b0;
    k = 0;
    wr(1'b0, 4'hF, 32'h89ABCDEF);
    wr(1'b1, 4'hF, 32'h00000001);
    chk("pre_en_seg", {24'h0, seg_n}, 32'hFF);
    chk("pre_en_an", {24'h0, an_n}, 32'hFF);

    // Full scan including the 7 -> 0 wrap
    for (int n = 0; n < 40; n++) begin
      clk1();
      j = (k / SD) % 8;
      chk($sformatf("scan_an k%0d", k), {24'h0, an_n}, {24'h0, an_exp(j)});
      chk($sformatf("scan_seg k%0d", k), {24'h0, seg_n}, {24'h0, SCAN_EXP[j]});
    end
    chk("dout_ctrl_pre_rst", bus_if.Dout, 32'h00000001);

    // Reset mid-scan takes effect without a clock edge
    reset = 1'b1;
    #1;
    chk("midrst_seg", {24'h0, seg_n}, 32'hFF);
    chk("midrst_an", {24'h0, an_n}, 32'hFF);
    chk("midrst_dout", bus_if.Dout, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
    for (int n = 0; n < 6; n++) begin
      clk1();
      chk("post_rst_seg", {24'h0, seg_n}, 32'hFF);
      chk("post_rst_an", {24'h0, an_n}, 32'hFF);
    end

    // Byte enables
    wr(1'b0, 4'hF, 32'h12345678);
    wr(1'b0, 4'b0100, 32'hFFFFFFFF);
    bus_if.addr = 1'b0;
    clk1();
    chk("be_readback", bus_if.Dout, 32'h12FF5678);
    wr(1'b0, 4'b0000, 32'hFFFFFFFF);
    clk1();
    chk("be_zero_noop", bus_if.Dout, 32'h12FF5678);

    // CTRL readback masks unstored bits
    wr(1'b1, 4'hF, 32'hFFFFFFFF);
    clk1();
    chk("ctrl_readback", bus_if.Dout, 32'h00FFFF01);

    // DP on digit 0, digit 1 blanked
    wr(1'b1, 4'hF, 32'h00020101);
    for (int n = 0; n < 34; n++) begin
      clk1();
      j = (k / SD) % 8;
      chk($sformatf("dpbl_an k%0d", k), {24'h0, an_n}, {24'h0, an_exp(j)});
      chk($sformatf("dpbl_seg k%0d", k), {24'h0, seg_n},
          {24'h0, seg_exp(32'h12FF5678, j, 8'h01, 8'h02)});
    end

    // DATA write on the same edge as a scan step
    wr(1'b1, 4'hF, 32'h00000001);
    for (int n = 0; n < 8 && (k % SD) != SD - 1; n++) clk1();
    chk("align_phase", k % SD, SD - 1);
    bus_if.addr = 1'b0;
    bus_if.be   = 4'hF;
    bus_if.Din  = 32'hEDCBA987;
    bus_if.we   = 1'b1;
    clk1();
    bus_if.we   = 1'b0;
    j = (k / SD) % 8;
    chk("wstep_an", {24'h0, an_n}, {24'h0, an_exp(j)});
    chk("wstep_old_seg", {24'h0, seg_n}, {24'h0, seg_exp(32'h12FF5678, j, 8'h00, 8'h00)});
    clk1();
    chk("wstep_an2", {24'h0, an_n}, {24'h0, an_exp(j)});
    chk("wstep_new_seg", {24'h0, seg_n}, {24'h0, seg_exp(32'hEDCBA987, j, 8'h00, 8'h00)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
